// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches words over a req/ack handshake,
// hands them to the decoder over valid/ready and computes the next PC on consume.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc,
  input  logic        is_jump,
  input  logic [25:0] addr26,
  input  logic        is_branch,
  input  logic        branch_taken,
  input  logic [15:0] imm16,
  input  logic        is_jr,
  input  logic [31:0] jr_target,
  output logic        fault
);

  // state    | meaning
  // REQ      | request issued (or about to be, first cycle after reset)
  // WAIT_ACK | request outstanding, waiting for imem_ack
  // VALID    | instruction holds a word waiting for the decoder
  // FAULT    | misaligned jr consumed; halted until reset
  typedef enum logic [1:0] {REQ, WAIT_ACK, VALID, FAULT} state_t;

  state_t      state, state_nx;
  logic        req_nx;
  logic        load_instr;
  logic        consume;
  logic        jr_misaligned;
  logic [31:0] pc4;
  logic [31:0] br_off;
  logic [31:0] pc_nx;

  always_comb begin
    pc4    = pc + 32'd4;
    br_off = {{14{imm16[15]}}, imm16, 2'b00};
    if (is_jr)                         pc_nx = jr_target;
    else if (is_jump)                  pc_nx = {pc4[31:28], addr26, 2'b00};
    else if (is_branch && branch_taken) pc_nx = pc4 + br_off;
    else                               pc_nx = pc4;
  end

  always_comb begin
    state_nx      = state;
    load_instr    = 1'b0;
    consume       = 1'b0;
    jr_misaligned = is_jr && (jr_target[1:0] != 2'b00);
    case (state)
      // an ack is only honoured once the request line is actually up,
      // so a stale ack right after reset is dropped
      REQ: begin
        if (imem_req && imem_ack) begin
          state_nx   = VALID;
          load_instr = 1'b1;
        end else if (imem_req) begin
          state_nx = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (imem_ack) begin
          state_nx   = VALID;
          load_instr = 1'b1;
        end
      end
      VALID: begin
        if (instr_ready) begin
          consume  = 1'b1;
          state_nx = jr_misaligned ? FAULT : REQ;
        end
      end
      FAULT:   state_nx = FAULT;
      default: state_nx = REQ;
    endcase
    req_nx = (state_nx == REQ) || (state_nx == WAIT_ACK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= REQ;
      imem_req    <= 1'b0;
      pc          <= RESET_PC;
      instruction <= 32'h0;
    end else begin
      state    <= state_nx;
      imem_req <= req_nx;
      if (load_instr)
        instruction <= imem_rdata;
      if (consume && !jr_misaligned)
        pc <= pc_nx;
    end
  end

  assign imem_addr   = pc;
  assign instr_valid = (state == VALID);
  assign fault       = (state == FAULT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: handshake timing, next-PC vectors, fault and reset corners.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc;
  logic        is_jump;
  logic [25:0] addr26;
  logic        is_branch;
  logic        branch_taken;
  logic [15:0] imm16;
  logic        is_jr;
  logic [31:0] jr_target;
  logic        fault;

  int total = 0;
  int bad   = 0;

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instruction(instruction), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc(pc), .is_jump(is_jump), .addr26(addr26), .is_branch(is_branch),
    .branch_taken(branch_taken), .imm16(imm16), .is_jr(is_jr), .jr_target(jr_target),
    .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] start_pc;
    logic        jr;
    logic        jmp;
    logic [25:0] a26;
    logic        br;
    logic        tk;
    logic [15:0] imm;
    logic [31:0] jrt;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] exp_pc, input logic [31:0] data);
    int n = 0;
    while (!imem_req && n < 10) begin
      step();
      n++;
    end
    chk("fetch_req", {31'b0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, exp_pc);
    imem_ack   = 1'b1;
    imem_rdata = data;
    step();
    imem_ack = 1'b0;
    chk("fetch_valid", {31'b0, instr_valid}, 32'd1);
    chk("fetch_instr", instruction, data);
  endtask

  task automatic consume(input logic jr, input logic jmp, input logic [25:0] a26,
                         input logic br, input logic tk, input logic [15:0] imm,
                         input logic [31:0] jrt);
    is_jr = jr; is_jump = jmp; addr26 = a26;
    is_branch = br; branch_taken = tk; imm16 = imm; jr_target = jrt;
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    is_jr = 0; is_jump = 0; addr26 = '0; is_branch = 0; branch_taken = 0;
    imm16 = '0; jr_target = '0;
  endtask

  initial begin
    logic [31:0] cur;
    vecs[0] = '{32'h1000_0040, 1'b0, 1'b1, 26'h000_0010, 1'b0, 1'b0, 16'h0000, 32'h0, 32'h1000_0040};
    vecs[1] = '{32'h1000_0040, 1'b0, 1'b1, 26'h3FF_FFFF, 1'b0, 1'b0, 16'h0000, 32'h0, 32'h1FFF_FFFC};
    vecs[2] = '{32'h0000_0200, 1'b0, 1'b0, 26'h0,        1'b1, 1'b1, 16'hFFFE, 32'h0, 32'h0000_01FC};
    vecs[3] = '{32'h0000_0200, 1'b0, 1'b0, 26'h0,        1'b1, 1'b0, 16'hFFFE, 32'h0, 32'h0000_0204};
    vecs[4] = '{32'h0000_0200, 1'b1, 1'b1, 26'h000_0010, 1'b1, 1'b1, 16'h0004, 32'h0000_0800, 32'h0000_0800};
    vecs[5] = '{32'hFFFF_FFFC, 1'b0, 1'b0, 26'h0,        1'b0, 1'b0, 16'h0000, 32'h0, 32'h0000_0000};
    vecs[6] = '{32'h0000_0300, 1'b0, 1'b0, 26'h0,        1'b0, 1'b1, 16'h0010, 32'h0, 32'h0000_0304};
    vecs[7] = '{32'hF000_0000, 1'b0, 1'b1, 26'h000_0001, 1'b0, 1'b0, 16'h0000, 32'h0, 32'hF000_0004};
    vecs[8] = '{32'h0000_0400, 1'b0, 1'b0, 26'h0,        1'b1, 1'b1, 16'h0010, 32'h0, 32'h0000_0444};

    rst_n = 1'b0; imem_ack = 0; imem_rdata = '0; instr_ready = 0;
    is_jump = 0; addr26 = '0; is_branch = 0; branch_taken = 0; imm16 = '0;
    is_jr = 0; jr_target = '0;
    step(); step();
    chk("rst_pc", pc, 32'h100);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_fault", {31'b0, fault}, 32'd0);

    // best-case throughput: ack held high (first-cycle ack is ignored), ready held high
    imem_ack = 1'b1; instr_ready = 1'b1; imem_rdata = 32'hA000_0000;
    rst_n = 1'b1;
    step();
    chk("rel_req", {31'b0, imem_req}, 32'd1);
    chk("rel_valid", {31'b0, instr_valid}, 32'd0);
    chk("rel_addr", imem_addr, 32'h100);
    for (int k = 0; k < 3; k++) begin
      imem_rdata = 32'hA000_0000 + k;
      step();
      chk($sformatf("tp%0d_valid", k), {31'b0, instr_valid}, 32'd1);
      chk($sformatf("tp%0d_instr", k), instruction, 32'hA000_0000 + k);
      chk($sformatf("tp%0d_pc", k), pc, 32'h100 + 4 * k);
      step();
      chk($sformatf("tp%0d_next_valid", k), {31'b0, instr_valid}, 32'd0);
      chk($sformatf("tp%0d_next_req", k), {31'b0, imem_req}, 32'd1);
      chk($sformatf("tp%0d_next_pc", k), pc, 32'h100 + 4 * (k + 1));
    end

    // delayed ack, then stalled consumer with a stray ack during VALID
    imem_ack = 1'b0; instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("dly_req", {31'b0, imem_req}, 32'd1);
      chk("dly_addr", imem_addr, 32'h10C);
      chk("dly_valid", {31'b0, instr_valid}, 32'd0);
    end
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    step();
    imem_rdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 4; k++) begin
      chk("stall_valid", {31'b0, instr_valid}, 32'd1);
      chk("stall_instr", instruction, 32'h1234_5678);
      chk("stall_pc", pc, 32'h10C);
      step();
    end
    imem_ack = 1'b0; instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("stall_done_pc", pc, 32'h110);
    chk("stall_done_req", {31'b0, imem_req}, 32'd1);
    chk("stall_done_valid", {31'b0, instr_valid}, 32'd0);

    // next-PC vectors
    cur = 32'h110;
    for (int i = 0; i < 9; i++) begin
      fetch(cur, 32'h0000_1000 + i);
      consume(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, vecs[i].start_pc);
      chk($sformatf("vec%0d_start", i), pc, vecs[i].start_pc);
      fetch(vecs[i].start_pc, 32'h0000_2000 + i);
      consume(vecs[i].jr, vecs[i].jmp, vecs[i].a26, vecs[i].br, vecs[i].tk,
              vecs[i].imm, vecs[i].jrt);
      chk($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
      chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_pc);
      chk($sformatf("vec%0d_req", i), {31'b0, imem_req}, 32'd1);
      cur = vecs[i].exp_pc;
    end

    // misaligned jr halts fetch until reset
    fetch(cur, 32'h0000_3000);
    consume(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 32'h0000_0802);
    chk("flt_fault", {31'b0, fault}, 32'd1);
    chk("flt_req", {31'b0, imem_req}, 32'd0);
    chk("flt_valid", {31'b0, instr_valid}, 32'd0);
    chk("flt_pc", pc, cur);
    imem_ack = 1'b1; instr_ready = 1'b1;
    step(); step(); step();
    chk("flt_hold_fault", {31'b0, fault}, 32'd1);
    chk("flt_hold_req", {31'b0, imem_req}, 32'd0);
    chk("flt_hold_valid", {31'b0, instr_valid}, 32'd0);
    chk("flt_hold_pc", pc, cur);
    imem_ack = 1'b0; instr_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("flt_rst_fault", {31'b0, fault}, 32'd0);
    chk("flt_rst_pc", pc, 32'h100);
    step();
    rst_n = 1'b1;
    step();

    // reset during WAIT_ACK, stale ack after release
    fetch(32'h100, 32'h0000_4000);
    consume(1'b0, 1'b1, 26'h000_0200, 1'b0, 1'b0, '0, '0);
    chk("wa_pc", pc, 32'h800);
    step();
    chk("wa_addr", imem_addr, 32'h800);
    chk("wa_req", {31'b0, imem_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("wa_rst_pc", pc, 32'h100);
    chk("wa_rst_req", {31'b0, imem_req}, 32'd0);
    chk("wa_rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("wa_rst_instr", instruction, 32'h0);
    step();
    rst_n = 1'b1;
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    step();
    chk("stale_valid", {31'b0, instr_valid}, 32'd0);
    chk("stale_req", {31'b0, imem_req}, 32'd1);
    chk("stale_addr", imem_addr, 32'h100);
    imem_ack = 1'b0;
    fetch(32'h100, 32'h0000_5000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the single-cycle MIPS processor. It holds the program counter, fetches instruction words from instruction memory over a request/acknowledge handshake, and presents each word to the control decoder with a valid/ready handshake. Control flow comes back from the decoder: jump, branch, and jump-register redirects plus the jump/branch immediates. The unit computes the next PC from these when an instruction is consumed.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  fetch address; always equals pc.
- imem_ack  input  1  memory has valid data on imem_rdata this cycle.
- imem_rdata  input  32  fetched instruction word.
- instruction  output  32  instruction word presented to the decoder.
- instr_valid  output  1  instruction holds a fetched, unconsumed word.
- instr_ready  input  1  decoder/datapath consumes the instruction this cycle.
- pc  output  32  address of the current instruction.
- is_jump  input  1  the current instruction is an absolute jump.
- addr26  input  26  jump target field.
- is_branch  input  1  the current instruction is a conditional branch.
- branch_taken  input  1  branch condition result from the datapath.
- imm16  input  16  branch offset field, in words.
- is_jr  input  1  the current instruction is a register jump.
- jr_target  input  32  register jump target.
- fault  output  1  a misaligned jr_target was consumed; fetch is halted.

## Operation

- States:
  - REQ: imem_req=1.
  - WAIT_ACK: imem_req=1.
  - VALID: instr_valid=1.
  - FAULT: all idle, fault=1.
- REQ/WAIT_ACK:
  - imem_req and imem_addr stay asserted and stable until imem_ack.
  - On imem_ack, imem_rdata is registered into instruction and the state moves to VALID.
  - REQ goes to WAIT_ACK if imem_ack is low.
- VALID:
  - instruction and pc stay stable until instr_valid && instr_ready.
  - Redirect inputs are sampled only in the consume cycle and are ignored otherwise.
- Next PC, with pc4 = pc + 4. Priority is is_jr > is_jump > is_branch&&branch_taken > sequential:
  - jr: jr_target.
  - jump: {pc4[31:28], addr26, 2'b00}.
  - taken branch: pc4 + {{14{imm16[15]}}, imm16, 2'b00}.
  - otherwise: pc4.
- Arithmetic is modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0.
- Consume cycle: pc updates to the next PC and the state returns to REQ. If is_jr && jr_target[1:0]!=0, the state goes to FAULT instead and pc is left unchanged.
- FAULT is left only by reset.
- is_branch with branch_taken=0 is sequential. branch_taken is ignored when is_branch=0.

## Timing

- Reset (asynchronous, immediate):
  - pc=RESET_PC, state=REQ, instruction=0, instr_valid=0, fault=0.
  - imem_req is 0 while rst_n is low and goes to 1 on the first edge after release.
- Outputs are registered. imem_addr is always pc.
- imem_ack sampled in cycle N puts instr_valid=1 with the new instruction in cycle N+1.
- A consume in cycle M gives the new pc and imem_req=1 in cycle M+1.
- Best-case throughput is one instruction per 2 cycles (ack in the request cycle, ready held high).
- imem_ack outside REQ/WAIT_ACK is ignored.
- Reset mid-request or mid-VALID abandons the fetch. The next request goes to RESET_PC, and any later stale ack is ignored until a new request is issued.
- instr_ready while instr_valid=0 has no effect.

## Test plan

- Reset with RESET_PC=32'h0000_0100 and ack in the request cycle, ready high: pc sequence 0x100, 0x104, 0x108; instr_valid every second cycle; instruction equals imem_rdata.
- Ack delayed 3 cycles, then ready held low for 4 cycles: imem_addr stable throughout; instruction stable while valid; pc does not advance until consume.
- Jump at pc=0x1000_0040 with addr26=26'h000_0010: next imem_addr=0x1000_0040; with addr26=26'h3FF_FFFF, next imem_addr=0x1FFF_FFFC.
- Branch at pc=0x200, imm16=16'hFFFE, taken: next pc=0x1FC. Same but not taken: 0x204. is_jr and is_jump both high with jr_target=0x800: next pc=0x800.
- pc=0xFFFF_FFFC sequential consume gives pc=0. A consume with is_jr and jr_target=0x802 raises fault and drops imem_req; instr_valid stays low; only rst_n recovers to RESET_PC.
- Assert rst_n low during WAIT_ACK, then ack arrives after release: outputs return to reset values immediately, and the first fetch after release is RESET_PC.
